vertex_streamer: RTL

VERTEX_STREAMER -- requirements
Module: vertex_streamer

---
 rtl/vertex_streamer_if.sv | 33 +++
 rtl/vertex_streamer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vertex_streamer_if.sv
// Bundle between the vertex streamer, its vertex memory, the distance unit
// and the requester. slave = streamer side, master = environment side.
interface vertex_streamer_if #(
  parameter int DIM    = 9,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
);
  logic              start_in;
  logic [15:0]       vertex_id_in;
  logic              ready_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [WIDTH-1:0]  mem_data_in;
  logic              data_valid_out [DIM-1:0];
  logic [WIDTH-1:0]  vertex_pos_out [DIM-1:0];
  logic              dist_valid_in;
  logic [31:0]       dist_sq_in;
  logic              result_valid_out;
  logic [31:0]       result_dist_out;
  logic [15:0]       result_id_out;
  logic              error_out;

  modport slave (
    input  start_in, vertex_id_in, mem_data_in, dist_valid_in, dist_sq_in,
    output ready_out, mem_addr_out, data_valid_out, vertex_pos_out,
           result_valid_out, result_dist_out, result_id_out, error_out
  );

  modport master (
    output start_in, vertex_id_in, mem_data_in, dist_valid_in, dist_sq_in,
    input  ready_out, mem_addr_out, data_valid_out, vertex_pos_out,
           result_valid_out, result_dist_out, result_id_out, error_out
  );
endinterface

// File: rtl/vertex_streamer.sv
// Streams one DIM-coordinate vertex from memory to a distance unit and returns its result.
// Optional WAIT_DIST watchdog: define VERTEX_STREAMER_TIMEOUT_EN.
module vertex_streamer #(
  parameter int DIM     = 9,
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  vertex_streamer_if.slave bus
);
  localparam int CNT_W = $clog2(DIM + 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_DIST, DONE} state_t;

  state_t            r_state, w_state_next;
  logic [15:0]       r_id;
  logic [ADDR_W-1:0] r_base, r_mem_addr, w_base, w_issue_addr;
  logic [CNT_W-1:0]  r_cnt, r_strb_cnt, w_issue_idx;
  logic              w_start, w_issue, w_all_strobed, w_accept, w_timeout;
  logic              r_pv   [MEM_LAT];
  logic [CNT_W-1:0]  r_pidx [MEM_LAT];
  logic              r_valid [DIM];
  logic [WIDTH-1:0]  r_pos   [DIM];
  logic              r_res_valid;
  logic [31:0]       r_res_dist;
  logic [15:0]       r_res_id;

  assign w_start      = (r_state == IDLE) && bus.start_in;
  assign w_base       = ADDR_W'(32'(bus.vertex_id_in) * 32'(DIM));
  assign w_issue      = w_start || ((r_state == FETCH) && (r_cnt != CNT_W'(DIM - 1)));
  assign w_issue_idx  = (r_state == IDLE) ? '0 : r_cnt + CNT_W'(1);
  assign w_issue_addr = ((r_state == IDLE) ? w_base : r_base) + ADDR_W'(w_issue_idx);
  // The last strobe is always dimension DIM-1; results count only after it has dropped.
  assign w_all_strobed = (r_strb_cnt == CNT_W'(DIM)) && !r_valid[DIM-1];
  assign w_accept      = (r_state == WAIT_DIST) && w_all_strobed && bus.dist_valid_in;

`ifdef VERTEX_STREAMER_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_err;

  assign w_timeout = (r_state == WAIT_DIST) && w_all_strobed && !bus.dist_valid_in
                     && (r_wdog == 8'd254);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err  <= w_timeout;
      r_wdog <= ((r_state == WAIT_DIST) && w_all_strobed) ? r_wdog + 8'd1 : 8'd0;
    end
  end

  assign bus.error_out = r_err;
`else
  assign w_timeout     = 1'b0;
  assign bus.error_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (bus.start_in) w_state_next = FETCH;
      FETCH:     if (r_cnt == CNT_W'(DIM - 1)) w_state_next = WAIT_DIST;
      WAIT_DIST: if (w_accept || w_timeout) w_state_next = DONE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_id        <= '0;
      r_base      <= '0;
      r_mem_addr  <= '0;
      r_cnt       <= '0;
      r_strb_cnt  <= '0;
      r_res_valid <= 1'b0;
      r_res_dist  <= '0;
      r_res_id    <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        r_pv[i]   <= 1'b0;
        r_pidx[i] <= '0;
      end
      for (int d = 0; d < DIM; d++) begin
        r_valid[d] <= 1'b0;
        r_pos[d]   <= '0;
      end
    end else begin
      // Stage 0 tags the address currently on the bus; the last stage lines up with its data.
      r_pv[0]   <= w_issue;
      r_pidx[0] <= w_issue_idx;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pidx[i] <= r_pidx[i-1];
      end
      for (int d = 0; d < DIM; d++) begin
        r_valid[d] <= r_pv[MEM_LAT-1] && (r_pidx[MEM_LAT-1] == CNT_W'(d));
        if (r_pv[MEM_LAT-1] && (r_pidx[MEM_LAT-1] == CNT_W'(d)))
          r_pos[d] <= bus.mem_data_in;
      end
      if (r_pv[MEM_LAT-1]) r_strb_cnt <= r_strb_cnt + CNT_W'(1);
      if (w_issue)         r_mem_addr <= w_issue_addr;
      if (r_state == FETCH) r_cnt <= r_cnt + CNT_W'(1);
      if (w_start) begin
        r_id       <= bus.vertex_id_in;
        r_base     <= w_base;
        r_cnt      <= '0;
        r_strb_cnt <= '0;
      end
      r_res_valid <= w_accept || w_timeout;
      if (w_accept) begin
        r_res_dist <= bus.dist_sq_in;
        r_res_id   <= r_id;
      end else if (w_timeout) begin
        r_res_dist <= '1;
        r_res_id   <= r_id;
      end
    end
  end

  assign bus.ready_out        = (r_state == IDLE);
  assign bus.mem_addr_out     = r_mem_addr;
  assign bus.result_valid_out = r_res_valid;
  assign bus.result_dist_out  = r_res_dist;
  assign bus.result_id_out    = r_res_id;

  for (genvar gi = 0; gi < DIM; gi++) begin : g_out
    assign bus.data_valid_out[gi] = r_valid[gi];
    assign bus.vertex_pos_out[gi] = r_pos[gi];
  end
endmodule
